// File: rtl/ch_point_buf_if.sv
// ch_point_buf_if: measurement-point input, bus read port and status signals
// of ch_point_buf. The slave modport is the buffer; the master modport is
// the side that drives points and reads the waveform back.
interface ch_point_buf_if #(
    parameter int V_W = 16,
    parameter int T_W = 10
);
    logic           arm_i;
    logic           point_rdy_i;
    logic [V_W-1:0] point_v_i;
    logic [T_W-1:0] point_t_i;
    logic           rd_en_i;
    logic [T_W-1:0] rd_addr_i;
    logic [V_W-1:0] rd_data_o;
    logic           rd_valid_o;
    logic           busy_o;
    logic           done_o;
    logic           irq_o;
    logic           ovf_o;
    logic [T_W:0]   cnt_o;
    logic [V_W-1:0] min_v_o;
    logic [V_W-1:0] max_v_o;
    logic [T_W-1:0] min_t_o;
    logic [T_W-1:0] max_t_o;

    modport slave (
        input  arm_i, point_rdy_i, point_v_i, point_t_i, rd_en_i, rd_addr_i,
        output rd_data_o, rd_valid_o, busy_o, done_o, irq_o, ovf_o, cnt_o,
               min_v_o, max_v_o, min_t_o, max_t_o
    );

    modport master (
        output arm_i, point_rdy_i, point_v_i, point_t_i, rd_en_i, rd_addr_i,
        input  rd_data_o, rd_valid_o, busy_o, done_o, irq_o, ovf_o, cnt_o,
               min_v_o, max_v_o, min_t_o, max_t_o
    );
endinterface

// File: rtl/ch_point_buf.sv
// ch_point_buf: capture buffer for the sweep points reported by ch_measure_ctl.
// Each new point (rising edge of point_rdy_i) stores its voltage code at the
// address given by its delay code. The sweep ends when the last delay code
// arrives (done level + one-cycle irq). A synchronous read port returns the
// captured waveform one cycle after the request.
// Optional feature: define CH_POINT_BUF_MINMAX_EN to build the running
// min/max voltage tracker; otherwise the min/max outputs are tied to 0.
module ch_point_buf #(
    parameter int V_W = 16,
    parameter int T_W = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    ch_point_buf_if.slave bus
);
    localparam int              DEPTH   = 1 << T_W;
    localparam logic [T_W-1:0]  T_LAST  = {T_W{1'b1}};
    localparam logic [T_W:0]    CNT_MAX = {1'b1, {T_W{1'b0}}};
    localparam logic [T_W:0]    CNT_ONE = {{T_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e         state_q;
    logic           point_rdy_q;
    logic           busy_q;
    logic           done_q;
    logic           irq_q;
    logic           ovf_q;
    logic [T_W:0]   cnt_q;
    logic [V_W-1:0] rd_data_q;
    logic           rd_valid_q;
    logic [V_W-1:0] mem_q [DEPTH];

    logic           pt_evt_s;
    logic           wr_en_s;

    // New-point detection and write qualification (arm wins over a point).
    always_comb begin
        pt_evt_s = bus.point_rdy_i & ~point_rdy_q;
        wr_en_s  = rst_ni & (state_q == S_CAPTURE) & pt_evt_s & ~bus.arm_i;
    end

    // Sweep control FSM with registered status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            point_rdy_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            point_rdy_q <= bus.point_rdy_i;
            irq_q       <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.arm_i) begin
                        state_q <= S_CAPTURE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                    end else if (pt_evt_s) begin
                        ovf_q   <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (bus.arm_i) begin
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                    end else if (pt_evt_s) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                        if (bus.point_t_i == T_LAST) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            irq_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Waveform storage: not reset, so contents survive reset and re-arm.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[bus.point_t_i] <= bus.point_v_i;
        end
    end

    // Synchronous read port; data holds between requests, read-during-write sees old data.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_en_i;
            if (bus.rd_en_i) begin
                rd_data_q <= mem_q[bus.rd_addr_i];
            end
        end
    end

`ifdef CH_POINT_BUF_MINMAX_EN
    logic [V_W-1:0] min_v_q;
    logic [V_W-1:0] max_v_q;
    logic [T_W-1:0] min_t_q;
    logic [T_W-1:0] max_t_q;

    // Running min/max over accepted points; strict compares keep the earlier point on ties.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.arm_i) begin
            min_v_q <= {V_W{1'b1}};
            max_v_q <= '0;
            min_t_q <= '0;
            max_t_q <= '0;
        end else if (wr_en_s) begin
            if (bus.point_v_i < min_v_q) begin
                min_v_q <= bus.point_v_i;
                min_t_q <= bus.point_t_i;
            end
            if (bus.point_v_i > max_v_q) begin
                max_v_q <= bus.point_v_i;
                max_t_q <= bus.point_t_i;
            end
        end
    end

    assign bus.min_v_o = min_v_q;
    assign bus.max_v_o = max_v_q;
    assign bus.min_t_o = min_t_q;
    assign bus.max_t_o = max_t_q;
`else
    assign bus.min_v_o = '0;
    assign bus.max_v_o = '0;
    assign bus.min_t_o = '0;
    assign bus.max_t_o = '0;
`endif

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.irq_o      = irq_q;
    assign bus.ovf_o      = ovf_q;
    assign bus.cnt_o      = cnt_q;
    assign bus.rd_data_o  = rd_data_q;
    assign bus.rd_valid_o = rd_valid_q;
endmodule

// File: tb/tb_ch_point_buf.sv
// tb_ch_point_buf: directed + randomized bench for ch_point_buf with a
// behavioural sweep model (mode flag, point list, memory image).
// Honours CH_POINT_BUF_MINMAX_EN the same way as the design.
module tb_ch_point_buf;
    localparam int V_W = 16;
    localparam int T_W = 10;
    localparam int N   = 1 << T_W;

    logic clk;
    logic rst_n;

    ch_point_buf_if #(.V_W(V_W), .T_W(T_W)) bus ();

    ch_point_buf #(.V_W(V_W), .T_W(T_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct { int t; int v; } pt_t;
    pt_t      pts[$];
    int       m_mode;          // 0 idle, 1 capturing, 2 complete
    int       m_cnt;
    bit       m_done;
    bit       m_ovf;
    int       m_mem [N];
    bit       m_written [N];

    int vectors     = 0;
    int miscompares = 0;
    int irq_cnt     = 0;
    int rnd_ts[$];

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_done = 1'b0; m_ovf = 1'b0; pts.delete();
    endtask

    task automatic model_arm();
        m_mode = 1; m_cnt = 0; m_done = 1'b0; m_ovf = 1'b0; pts.delete();
    endtask

    task automatic model_point(input int t, input int v);
        pt_t p;
        if (m_mode != 1) begin
            m_ovf = 1'b1;
        end else begin
            m_mem[t] = v;
            m_written[t] = 1'b1;
            m_cnt = (m_cnt + 1 > N) ? N : m_cnt + 1;
            p.t = t; p.v = v;
            pts.push_back(p);
            if (t == N - 1) begin
                m_mode = 2;
                m_done = 1'b1;
            end
        end
    endtask

    // Expected min/max: smallest/largest value, delay code of its first occurrence.
    task automatic expect_mm(output int mnv, output int mnt, output int mxv, output int mxt);
        mnv = 'hFFFF; mnt = 0; mxv = 0; mxt = 0;
`ifdef CH_POINT_BUF_MINMAX_EN
        foreach (pts[i]) begin
            if (pts[i].v < mnv) mnv = pts[i].v;
            if (pts[i].v > mxv) mxv = pts[i].v;
        end
        for (int i = pts.size() - 1; i >= 0; i--) begin
            if (pts[i].v == mnv) mnt = pts[i].t;
            if (pts[i].v == mxv && mxv != 0) mxt = pts[i].t;
        end
`else
        mnv = 0;
`endif
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        int mnv, mnt, mxv, mxt;
        expect_mm(mnv, mnt, mxv, mxt);
        chk({tag, ".busy"}, 32'(bus.busy_o), 32'(m_mode == 1));
        chk({tag, ".done"}, 32'(bus.done_o), 32'(m_done));
        chk({tag, ".ovf"},  32'(bus.ovf_o),  32'(m_ovf));
        chk({tag, ".cnt"},  32'(bus.cnt_o),  32'(m_cnt));
        chk({tag, ".irq"},  32'(bus.irq_o),  32'd0);
        chk({tag, ".min_v"}, 32'(bus.min_v_o), 32'(mnv));
        chk({tag, ".min_t"}, 32'(bus.min_t_o), 32'(mnt));
        chk({tag, ".max_v"}, 32'(bus.max_v_o), 32'(mxv));
        chk({tag, ".max_t"}, 32'(bus.max_t_o), 32'(mxt));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        if (bus.irq_o === 1'b1) irq_cnt++;
    endtask

    task automatic send_point(input int t, input int v, input int hold, input bit with_arm);
        bus.point_t_i   = T_W'(t);
        bus.point_v_i   = V_W'(v);
        bus.point_rdy_i = 1'b1;
        bus.arm_i       = with_arm;
        tick();
        bus.arm_i = 1'b0;
        for (int i = 1; i < hold; i++) tick();
        bus.point_rdy_i = 1'b0;
        tick();
        if (with_arm) model_arm();
        else          model_point(t, v);
    endtask

    task automatic do_arm();
        bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        tick();
        model_arm();
    endtask

    task automatic read_chk(input string tag, input int addr);
        bus.rd_en_i   = 1'b1;
        bus.rd_addr_i = T_W'(addr);
        tick();
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid_o), 32'd1);
        chk({tag, ".rd_data"},  32'(bus.rd_data_o),  32'(m_mem[addr]));
        bus.rd_en_i = 1'b0;
        tick();
        chk({tag, ".rd_valid_low"}, 32'(bus.rd_valid_o), 32'd0);
        chk({tag, ".rd_hold"},      32'(bus.rd_data_o),  32'(m_mem[addr]));
    endtask

    // ---------------- directed + randomized sequence ----------------
    initial begin
        int t;
        int v;
        bus.arm_i = 1'b0; bus.point_rdy_i = 1'b1; bus.point_v_i = '0;
        bus.point_t_i = '0; bus.rd_en_i = 1'b0; bus.rd_addr_i = '0;
        rst_n = 1'b0;
        model_reset();

        // Reset values, with point_rdy_i already high through reset.
        repeat (3) tick();
        check_status("reset");
        chk("reset.rd_valid", 32'(bus.rd_valid_o), 32'd0);
        chk("reset.rd_data",  32'(bus.rd_data_o),  32'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("release_high_no_edge.ovf", 32'(bus.ovf_o), 32'd0);
        bus.point_rdy_i = 1'b0;
        tick();

        // Point while idle is dropped and flagged.
        send_point(5, 16'h5555, 1, 1'b0);
        check_status("idle_ovf");

        // Arm clears the overflow flag.
        do_arm();
        check_status("arm1");

        // Full sweep, v = 3*t.
        irq_cnt = 0;
        for (int i = 0; i < N; i++) begin
            send_point(i, i * 3, 1, 1'b0);
            if (i == 511) check_status("sweep_mid");
        end
        check_status("sweep_end");
        chk("sweep.irq_pulses", 32'(irq_cnt), 32'd1);
        chk("sweep.cnt_full", 32'(bus.cnt_o), 32'd1024);
        read_chk("rd500", 500);
        chk("rd500.exact", 32'(bus.rd_data_o), 32'd1500);
        read_chk("rd1023", N - 1);
        for (int i = 0; i < 3; i++) read_chk("rd_sweep_rand", $urandom_range(N - 1, 0));

        // Point after completion: dropped, memory unchanged.
        send_point(3, 16'h0BAD, 1, 1'b0);
        check_status("done_ovf");
        read_chk("rd3_unchanged", 3);

        // Re-arm clears ovf/done/cnt.
        do_arm();
        check_status("arm2");

        // Level held 5 cycles is one point.
        send_point(7, 16'h1234, 5, 1'b0);
        check_status("level_hold");
        read_chk("rd7", 7);

        // Duplicate delay code: last write wins, count still increments.
        send_point(8, $urandom_range(16'hFFFE, 1), 1, 1'b0);
        send_point(8, $urandom_range(16'hFFFE, 1), 1, 1'b0);
        send_point(9, $urandom_range(16'hFFFE, 1), 1, 1'b0);
        send_point(10, $urandom_range(16'hFFFE, 1), 1, 1'b0);
        check_status("cnt5");
        read_chk("rd8_dup", 8);

        // Arm and point edge in the same cycle: arm wins, point not written.
        send_point(600, 16'h7777, 1, 1'b1);
        check_status("collision");
        read_chk("rd600_kept", 600);

        // Min/max ties keep earlier point.
        send_point(0, 100, 1, 1'b0);
        send_point(1, 40, 1, 1'b0);
        send_point(2, 250, 1, 1'b0);
        send_point(3, 40, 1, 1'b0);
        send_point(4, 250, 1, 1'b0);
        check_status("minmax");

        // Read and write to the same address in one cycle returns old data.
        bus.point_t_i = T_W'(1); bus.point_v_i = V_W'(777); bus.point_rdy_i = 1'b1;
        bus.rd_en_i = 1'b1; bus.rd_addr_i = T_W'(1);
        tick();
        chk("rdw.rd_valid", 32'(bus.rd_valid_o), 32'd1);
        chk("rdw.old_data", 32'(bus.rd_data_o), 32'(m_mem[1]));
        bus.point_rdy_i = 1'b0; bus.rd_en_i = 1'b0;
        tick();
        model_point(1, 777);
        read_chk("rdw.new_data", 1);

        // Randomized points within a sweep, then random readback.
        for (int i = 0; i < 40; i++) begin
            t = $urandom_range(N - 2, 0);
            v = $urandom_range(16'hFFFE, 1);
            rnd_ts.push_back(t);
            send_point(t, v, $urandom_range(3, 1), 1'b0);
        end
        check_status("random");
        for (int i = 0; i < 8; i++) read_chk("rd_rand", rnd_ts[$urandom_range(rnd_ts.size() - 1, 0)]);

        // Reset mid-sweep aborts to idle; a later point overflows.
        rst_n = 1'b0;
        tick();
        model_reset();
        check_status("mid_reset");
        rst_n = 1'b1;
        tick();
        send_point(20, 16'h0042, 1, 1'b0);
        check_status("post_reset_ovf");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
